// File: rtl/intersection_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intersection_controller: two-road light sequencer with pedestrian WALK.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module intersection_controller #(
    parameter int TICKS_PER_SEC = 24_000_000,
    parameter int GREEN_S       = 5,
    parameter int GREEN_MIN_S   = 2,
    parameter int AMBER_S       = 2,
    parameter int ALLRED_S      = 1,
    parameter int WALK_S        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_btn_n,
    output logic [2:0] led_a,
    output logic [2:0] led_b,
    output logic       walk_n,
    output logic [2:0] phase
);

    localparam int PRE_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int MAX_GA = (GREEN_S > AMBER_S) ? GREEN_S : AMBER_S;
    localparam int MAX_RW = (ALLRED_S > WALK_S) ? ALLRED_S : WALK_S;
    localparam int MAX_S  = (MAX_GA > MAX_RW) ? MAX_GA : MAX_RW;
    localparam int TMR_W  = (MAX_S > 1) ? $clog2(MAX_S) : 1;

    localparam logic [2:0] S_A_GRN = 3'd0;
    localparam logic [2:0] S_A_AMB = 3'd1;
    localparam logic [2:0] S_RED_A = 3'd2;
    localparam logic [2:0] S_B_GRN = 3'd3;
    localparam logic [2:0] S_B_AMB = 3'd4;
    localparam logic [2:0] S_RED_B = 3'd5;
    localparam logic [2:0] S_WALK  = 3'd6;

    localparam logic DIR_A = 1'b0;
    localparam logic DIR_B = 1'b1;

    // Head encoding is active-low: {amber, red, green}
    localparam logic [2:0] HEAD_GRN = 3'b110;
    localparam logic [2:0] HEAD_AMB = 3'b011;
    localparam logic [2:0] HEAD_RED = 3'b101;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       state_q, state_d;
    logic             next_dir_q, next_dir_d;
    logic             ped_pending_q, ped_pending_d;
    logic [2:0]       sync_q, sync_d;
    logic [2:0]       led_a_q, led_a_d;
    logic [2:0]       led_b_q, led_b_d;
    logic             walk_n_q, walk_n_d;
    logic             tick;
    logic             press;
    logic             green_done;

    always_comb begin
        tick       = (presc_q == PRE_W'(TICKS_PER_SEC - 1));
        presc_d    = tick ? '0 : presc_q + 1'b1;
        sync_d     = {sync_q[1:0], ped_btn_n};
        press      = sync_q[2] & ~sync_q[1];
        green_done = (timer_q == TMR_W'(GREEN_S - 1)) ||
                     (ped_pending_q && (timer_q >= TMR_W'(GREEN_MIN_S - 1)));

        state_d    = state_q;
        next_dir_d = next_dir_q;
        case (state_q)
            S_A_GRN: if (tick && green_done) state_d = S_A_AMB;
            S_A_AMB: if (tick && timer_q == TMR_W'(AMBER_S - 1)) state_d = S_RED_A;
            S_RED_A: if (tick && timer_q == TMR_W'(ALLRED_S - 1)) begin
                state_d    = ped_pending_q ? S_WALK : S_B_GRN;
                next_dir_d = DIR_B;
            end
            S_B_GRN: if (tick && green_done) state_d = S_B_AMB;
            S_B_AMB: if (tick && timer_q == TMR_W'(AMBER_S - 1)) state_d = S_RED_B;
            S_RED_B: if (tick && timer_q == TMR_W'(ALLRED_S - 1)) begin
                state_d    = ped_pending_q ? S_WALK : S_A_GRN;
                next_dir_d = DIR_A;
            end
            S_WALK:  if (tick && timer_q == TMR_W'(WALK_S - 1))
                state_d = (next_dir_q == DIR_A) ? S_A_GRN : S_B_GRN;
            default: state_d = S_RED_B;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        // A press on the WALK-entry edge must survive the clear
        if (press) begin
            ped_pending_d = 1'b1;
        end else if (state_d == S_WALK && state_q != S_WALK) begin
            ped_pending_d = 1'b0;
        end else begin
            ped_pending_d = ped_pending_q;
        end

        led_a_d  = HEAD_RED;
        led_b_d  = HEAD_RED;
        walk_n_d = 1'b1;
        case (state_d)
            S_A_GRN: led_a_d  = HEAD_GRN;
            S_A_AMB: led_a_d  = HEAD_AMB;
            S_B_GRN: led_b_d  = HEAD_GRN;
            S_B_AMB: led_b_d  = HEAD_AMB;
            S_WALK:  walk_n_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            timer_q       <= '0;
            state_q       <= S_RED_B;
            next_dir_q    <= DIR_A;
            ped_pending_q <= 1'b0;
            sync_q        <= 3'b111;
            led_a_q       <= HEAD_RED;
            led_b_q       <= HEAD_RED;
            walk_n_q      <= 1'b1;
        end else begin
            presc_q       <= presc_d;
            timer_q       <= timer_d;
            state_q       <= state_d;
            next_dir_q    <= next_dir_d;
            ped_pending_q <= ped_pending_d;
            sync_q        <= sync_d;
            led_a_q       <= led_a_d;
            led_b_q       <= led_b_d;
            walk_n_q      <= walk_n_d;
        end
    end

    assign led_a  = led_a_q;
    assign led_b  = led_b_q;
    assign walk_n = walk_n_q;
    assign phase  = state_q;

endmodule
`default_nettype wire
